// File: rtl/tpu_arith_pkg.sv
// -----------------------------------------------------------------------------
// tpu_arith_pkg
//   Shared definitions for the TPU arithmetic helpers.
//   - SUB_MODE_WRAP / SUB_MODE_SAT : encodings of the per-beat subtract mode bit.
//   - sub_clamp()                  : decides whether a subtract result is forced
//                                    to zero, given the mode and the borrow flag.
// -----------------------------------------------------------------------------
package tpu_arith_pkg;

    // Per-beat subtract mode carried alongside the operands.
    localparam logic SUB_MODE_WRAP = 1'b0;  // modulo-2^WIDTH result
    localparam logic SUB_MODE_SAT  = 1'b1;  // clamp to zero on borrow

    // Returns 1 when the raw difference must be replaced by zero.
    function automatic logic sub_clamp(input logic mode, input logic borrow);
        logic clamp;
        unique case (mode)
            SUB_MODE_WRAP: clamp = 1'b0;
            SUB_MODE_SAT:  clamp = borrow;
        endcase
        return clamp;
    endfunction

endpackage

// File: rtl/fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
//   Single-bit full adder, the leaf cell of the ripple subtract segments.
//   Ports:
//     a_i, b_i, cin_i : addend bits and carry in
//     sum_o           : a_i ^ b_i ^ cin_i
//     cout_o          : carry out
// -----------------------------------------------------------------------------
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic p;

    assign p      = a_i ^ b_i;
    assign sum_o  = p ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/sub_seg.sv
// -----------------------------------------------------------------------------
// sub_seg
//   Combinational SEG-bit ripple subtract segment: {cout, diff} = a + ~b + cin.
//   With cin = 1 on the least significant segment this is a - b in two's
//   complement; cout = 1 means "no borrow" out of this segment.
//   Parameters:
//     SEG  : segment width in bits
//   Ports:
//     a    : minuend slice
//     b    : subtrahend slice (inverted internally)
//     cin  : carry in (1 = no borrow into this slice)
//     diff : difference slice
//     cout : carry out (1 = no borrow out of this slice)
// -----------------------------------------------------------------------------
module sub_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] diff,
    output logic           cout
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        fulladder u_fa (
            .a_i    (a[i]),
            .b_i    (~b[i]),
            .cin_i  (c[i]),
            .sum_o  (diff[i]),
            .cout_o (c[i+1])
        );
    end

    assign cout = c[SEG];

endmodule

// File: rtl/sub_pipe.sv
// -----------------------------------------------------------------------------
// sub_pipe
//   Pipelined unsigned subtractor, out_diff = in_a - in_b, with the ripple-borrow
//   chain split into STAGES registered segments of SEG = WIDTH/STAGES bits.
//   Each beat carries its own wrap/saturate mode; the borrow flag is exported.
//   Latency is exactly STAGES cycles, throughput one beat per cycle.
//
//   Parameters:
//     WIDTH  : operand/result width, a multiple of STAGES
//     STAGES : number of pipeline segments (1..WIDTH)
//
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset, discards in-flight beats
//     in_valid   : operand beat valid
//     in_ready   : beat accepted this cycle (combinational from out side)
//     in_a, in_b : unsigned minuend / subtrahend
//     in_sat     : 1 = saturate to 0 on borrow, 0 = wrap
//     out_valid  : result beat valid
//     out_ready  : consumer accepts the result
//     out_diff   : result
//     out_borrow : 1 iff in_a < in_b (in both modes)
//
//   Datapath layout per stage register:
//     word : a rotating WIDTH-bit word. Stage s consumes the low SEG bits (the
//            next minuend slice) and shifts its finished diff slice in at the
//            top, so after STAGES stages the word holds the full difference in
//            natural bit order.
//     b    : the subtrahend shifted right by SEG per stage so the next segment
//            always reads its slice from the low bits. Not kept in the last
//            stage, where nothing consumes it.
//     carry, sat, valid : inter-segment carry, beat mode and stage occupancy.
// -----------------------------------------------------------------------------
module sub_pipe
    import tpu_arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
);

    localparam int SEG = WIDTH / STAGES;

    // Global advance: the whole pipe moves together, bubbles included, whenever
    // the output register is empty or being drained this cycle.
    logic adv;

    // Boundary s is the input of stage s; boundary STAGES is the output register.
    logic [WIDTH-1:0] bnd_word  [STAGES+1];
    logic [WIDTH-1:0] bnd_b     [STAGES];
    logic             bnd_carry [STAGES+1];
    logic             bnd_sat   [STAGES+1];
    logic             bnd_valid [STAGES+1];

    logic             borrow;

    assign bnd_word[0]  = in_a;
    assign bnd_b[0]     = in_b;
    assign bnd_carry[0] = 1'b1;  // a + ~b + 1 == a - b
    assign bnd_sat[0]   = in_sat;
    assign bnd_valid[0] = in_valid;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [SEG-1:0]   seg_diff;
        logic             seg_cout;
        logic [WIDTH-1:0] word_d;
        logic [WIDTH-1:0] word_q;
        logic             carry_q;
        logic             sat_q;
        logic             valid_q;

        sub_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (bnd_word[s][SEG-1:0]),
            .b    (bnd_b[s][SEG-1:0]),
            .cin  (bnd_carry[s]),
            .diff (seg_diff),
            .cout (seg_cout)
        );

        if (SEG == WIDTH) begin : g_single
            assign word_d = seg_diff;
        end else begin : g_rotate
            assign word_d = {seg_diff, bnd_word[s][WIDTH-1:SEG]};
        end

        // NOTE: state registers use non-blocking assignments so every stage
        // samples its predecessor's pre-edge value; blocking here would let a
        // beat race through several stages in one clock.
        // NOTE: data registers are reset as well as the valids, so the outputs
        // read as zero after reset rather than holding stale operands.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q  <= '0;
                carry_q <= 1'b0;
                sat_q   <= 1'b0;
                valid_q <= 1'b0;
            end else if (adv) begin
                word_q  <= word_d;
                carry_q <= seg_cout;
                sat_q   <= bnd_sat[s];
                valid_q <= bnd_valid[s];
            end
        end

        assign bnd_word[s+1]  = word_q;
        assign bnd_carry[s+1] = carry_q;
        assign bnd_sat[s+1]   = sat_q;
        assign bnd_valid[s+1] = valid_q;

        if (s < STAGES - 1) begin : g_fwd_b
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv) begin
                    b_q <= bnd_b[s] >> SEG;
                end
            end

            assign bnd_b[s+1] = b_q;
        end
    end

    // Output mux. A cleared carry register would read as borrow=1, so the flag
    // is qualified by out_valid to present 0 while the output is empty.
    assign out_valid  = bnd_valid[STAGES];
    assign borrow     = ~bnd_carry[STAGES];
    assign out_borrow = out_valid & borrow;
    assign out_diff   = sub_clamp(bnd_sat[STAGES], borrow) ? '0 : bnd_word[STAGES];

endmodule

// File: tb/tb_sub_pipe.sv
module tb_sub_pipe;
    import tpu_arith_pkg::*;

    // ---------------------------------------------------------------- main DUT
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_diff;
    logic       out_borrow;

    always #5 clk = ~clk;

    sub_pipe #(
        .WIDTH  (8),
        .STAGES (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sat     (in_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow)
    );

    // ------------------------------------------------------ random-run DUTs
    localparam int RW     = 16;
    localparam int NRAND  = 3;
    localparam int RBEATS = 3334;

    logic [RW-1:0] r_a         [NRAND];
    logic [RW-1:0] r_b         [NRAND];
    logic [RW-1:0] r_diff      [NRAND];
    logic          r_sat       [NRAND];
    logic          r_valid     [NRAND];
    logic          r_in_ready  [NRAND];
    logic          r_out_valid [NRAND];
    logic          r_ready     [NRAND];
    logic          r_borrow    [NRAND];

    for (genvar k = 0; k < NRAND; k++) begin : g_rand
        localparam int S = (k == 0) ? 1 : (k == 1) ? 4 : 16;
        sub_pipe #(
            .WIDTH  (RW),
            .STAGES (S)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (r_valid[k]),
            .in_ready   (r_in_ready[k]),
            .in_a       (r_a[k]),
            .in_b       (r_b[k]),
            .in_sat     (r_sat[k]),
            .out_valid  (r_out_valid[k]),
            .out_ready  (r_ready[k]),
            .out_diff   (r_diff[k]),
            .out_borrow (r_borrow[k])
        );
    end

    // ------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW:0] model16(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                            input logic sat);
        logic          br;
        logic [RW-1:0] d;
        br = (a < b);
        d  = a - b;
        if (sat && br) d = '0;
        return {br, d};
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sat;
        logic [7:0] d;
        logic       brw;
    } vec_t;

    vec_t vecs [11];

    task automatic send_vec(input vec_t v, input string tag);
        @(negedge clk);
        in_a      = v.a;
        in_b      = v.b;
        in_sat    = v.sat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat2_valid"}, out_valid, 1'b1);
        check({tag, "_diff"}, out_diff, v.d);
        check({tag, "_borrow"}, out_borrow, v.brw);
    endtask

    // Backpressure stream contents and hand-computed {borrow, diff}.
    logic [7:0] bp_a   [4];
    logic [7:0] bp_b   [4];
    logic       bp_sat [4];
    logic [8:0] bp_exp [4];

    int            sent   [NRAND];
    int            recvd  [NRAND];
    logic          acc_last [NRAND];
    logic [RW:0]   sb     [NRAND][$];

    initial begin
        vecs[0]  = '{8'h35, 8'h12, SUB_MODE_WRAP, 8'h23, 1'b0};
        vecs[1]  = '{8'h10, 8'h01, SUB_MODE_WRAP, 8'h0F, 1'b0};
        vecs[2]  = '{8'h10, 8'h20, SUB_MODE_WRAP, 8'hF0, 1'b1};
        vecs[3]  = '{8'h10, 8'h20, SUB_MODE_SAT,  8'h00, 1'b1};
        vecs[4]  = '{8'h5A, 8'h5A, SUB_MODE_SAT,  8'h00, 1'b0};
        vecs[5]  = '{8'h00, 8'hFF, SUB_MODE_WRAP, 8'h01, 1'b1};
        vecs[6]  = '{8'h00, 8'hFF, SUB_MODE_SAT,  8'h00, 1'b1};
        vecs[7]  = '{8'hFF, 8'h00, SUB_MODE_SAT,  8'hFF, 1'b0};
        vecs[8]  = '{8'h80, 8'h7F, SUB_MODE_WRAP, 8'h01, 1'b0};
        vecs[9]  = '{8'hC3, 8'h3C, SUB_MODE_SAT,  8'h87, 1'b0};
        vecs[10] = '{8'h3C, 8'hC3, SUB_MODE_WRAP, 8'h79, 1'b1};

        bp_a[0] = 8'h35; bp_b[0] = 8'h12; bp_sat[0] = SUB_MODE_WRAP; bp_exp[0] = 9'h023;
        bp_a[1] = 8'h10; bp_b[1] = 8'h01; bp_sat[1] = SUB_MODE_WRAP; bp_exp[1] = 9'h00F;
        bp_a[2] = 8'h00; bp_b[2] = 8'hFF; bp_sat[2] = SUB_MODE_WRAP; bp_exp[2] = 9'h101;
        bp_a[3] = 8'h00; bp_b[3] = 8'hFF; bp_sat[3] = SUB_MODE_SAT;  bp_exp[3] = 9'h100;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sat    = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < NRAND; k++) begin
            r_valid[k]  = 1'b0;
            r_ready[k]  = 1'b0;
            r_a[k]      = '0;
            r_b[k]      = '0;
            r_sat[k]    = 1'b0;
            sent[k]     = 0;
            recvd[k]    = 0;
            acc_last[k] = 1'b0;
        end

        // ---- reset state
        #2 rst_n = 1'b0;
        #10;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_diff", out_diff, 8'h00);
        check("rst_out_borrow", out_borrow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single beats, latency and arithmetic
        for (int i = 0; i < 11; i++) begin
            send_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- back-to-back wrap then sat
        @(negedge clk);
        in_a = 8'h10; in_b = 8'h20; in_sat = SUB_MODE_WRAP; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_sat = SUB_MODE_SAT;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_wrap_valid", out_valid, 1'b1);
        check("b2b_wrap", {out_borrow, out_diff}, 9'h1F0);
        @(negedge clk);
        check("b2b_sat_valid", out_valid, 1'b1);
        check("b2b_sat", {out_borrow, out_diff}, 9'h100);
        @(negedge clk);
        check("b2b_drained", out_valid, 1'b0);

        // ---- backpressure: 4 beats, out_ready low for the first 6 cycles
        begin
            int idx_in;
            int idx_out;
            idx_in  = 0;
            idx_out = 0;
            for (int c = 0; c < 30 && idx_out < 4; c++) begin
                @(negedge clk);
                out_ready = (c >= 6);
                if (idx_in < 4) begin
                    in_a     = bp_a[idx_in];
                    in_b     = bp_b[idx_in];
                    in_sat   = bp_sat[idx_in];
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (c == 5) begin
                    check("bp_accepted_before_stall", idx_in, 2);
                    check("bp_in_ready_low", in_ready, 1'b0);
                    check("bp_hold_valid", out_valid, 1'b1);
                    check("bp_hold_diff", {out_borrow, out_diff}, 9'h023);
                end
                if (out_valid && out_ready) begin
                    check($sformatf("bp_out%0d", idx_out), {out_borrow, out_diff}, bp_exp[idx_out]);
                    idx_out++;
                end
                if (in_valid && in_ready) idx_in++;
            end
            check("bp_out_count", idx_out, 4);
            begin
                int extra;
                extra = 0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    #1;
                    if (out_valid) extra++;
                end
                check("bp_no_duplicate", extra, 0);
            end
        end

        // ---- reset with two beats in flight
        @(negedge clk);
        in_a = 8'h44; in_b = 8'h11; in_sat = SUB_MODE_WRAP; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_a = 8'h12; in_b = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_rst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_diff", out_diff, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int ghost;
            ghost = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                if (out_valid) ghost++;
            end
            check("mid_rst_no_emit", ghost, 0);
        end

        // ---- random streams on WIDTH=16, STAGES 1/4/16
        for (int c = 0; c < 40000; c++) begin
            bit all_done;
            all_done = 1'b1;
            for (int k = 0; k < NRAND; k++) if (recvd[k] < RBEATS) all_done = 1'b0;
            if (all_done) break;
            @(negedge clk);
            for (int k = 0; k < NRAND; k++) begin
                if (acc_last[k]) r_valid[k] = 1'b0;
                if (!r_valid[k] && sent[k] < RBEATS && $urandom_range(0, 3) != 0) begin
                    r_a[k]     = 16'($urandom);
                    r_b[k]     = ($urandom_range(0, 7) == 0) ? r_a[k] : 16'($urandom);
                    r_sat[k]   = 1'($urandom_range(0, 1));
                    r_valid[k] = 1'b1;
                end
                r_ready[k] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int k = 0; k < NRAND; k++) begin
                acc_last[k] = r_valid[k] && r_in_ready[k];
                if (acc_last[k]) begin
                    sb[k].push_back(model16(r_a[k], r_b[k], r_sat[k]));
                    sent[k]++;
                end
                if (r_out_valid[k] && r_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("rand%0d_spurious_out", k), 1, 0);
                    end else begin
                        check($sformatf("rand%0d_beat%0d", k, recvd[k]),
                              {r_borrow[k], r_diff[k]}, sb[k].pop_front());
                    end
                    recvd[k]++;
                end
            end
        end
        for (int k = 0; k < NRAND; k++) begin
            check($sformatf("rand%0d_beats_received", k), recvd[k], RBEATS);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
